// File: rtl/bus_hold_arbiter.sv
// Round-robin HOLD/HLDA bus arbiter: takes the 8088 local bus on behalf of NUM_REQ DMA requesters.
// Optional HOLD_CHAIN_EN: hand the bus straight to the next requester without releasing HOLD.
module bus_hold_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic                       HLDA,
  output logic                       HOLD,
  output logic [NUM_REQ-1:0]         GNT,
  output logic [$clog2(NUM_REQ)-1:0] OWNER,
  output logic                       BUSY
);

  localparam int OW = $clog2(NUM_REQ);
  localparam logic [7:0] MAX_C = 8'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_ACQ, S_GRANT, S_DROP, S_RELS} state_t;

  state_t               state_q, state_d;
  logic                 hold_q, hold_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [7:0]           cnt_q, cnt_d;
`ifdef HOLD_CHAIN_EN
  localparam int CW = $clog2(NUM_REQ + 1);
  logic [CW-1:0]        chain_q, chain_d;
`endif

  logic                 req_any;
  logic [OW-1:0]        win;
  logic [OW-1:0]        ptr_after_owner;

  // First set request at or after ptr, wrapping; rotate then priority-encode from bit 0.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [OW-1:0] ptr);
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] tmp;
    int                 off;
    int                 w;
    rot = NUM_REQ'({req, req} >> ptr);
    off = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      tmp = rot >> j;
      if (tmp[0]) off = j;
    end
    w = int'(ptr) + off;
    if (w >= NUM_REQ) w = w - NUM_REQ;
    return OW'(w);
  endfunction

  assign req_any         = |REQ;
  assign win             = rr_pick(REQ, ptr_q);
  assign ptr_after_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`ifdef HOLD_CHAIN_EN
    chain_d = chain_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef HOLD_CHAIN_EN
        chain_d = '0;
`endif
        if (req_any) begin
          hold_d  = 1'b1;
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        if (HLDA) begin
          if (req_any) begin
            gnt_d   = ONE << win;
            owner_d = win;
            cnt_d   = 8'd1;
            state_d = S_GRANT;
`ifdef HOLD_CHAIN_EN
            chain_d = CW'(1);
`endif
          end else begin
            state_d = S_DROP;
          end
        end
      end
      S_GRANT: begin
        // Losing HLDA mid-burst is a protocol violation: abandon the grant and release at once.
        if (!HLDA) begin
          gnt_d   = '0;
          hold_d  = 1'b0;
          ptr_d   = ptr_after_owner;
          state_d = S_RELS;
        end else if (!REQ[owner_q] || cnt_q == MAX_C) begin
          gnt_d   = '0;
          ptr_d   = ptr_after_owner;
          state_d = S_DROP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DROP: begin
`ifdef HOLD_CHAIN_EN
        if (HLDA && req_any && chain_q < CW'(NUM_REQ)) begin
          gnt_d   = ONE << win;
          owner_d = win;
          cnt_d   = 8'd1;
          chain_d = chain_q + CW'(1);
          state_d = S_GRANT;
        end else begin
          hold_d  = 1'b0;
          state_d = S_RELS;
        end
`else
        hold_d  = 1'b0;
        state_d = S_RELS;
`endif
      end
      S_RELS: begin
        if (!HLDA) state_d = S_IDLE;
      end
      default: begin
        gnt_d   = '0;
        hold_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      hold_q  <= 1'b0;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
`ifdef HOLD_CHAIN_EN
      chain_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef HOLD_CHAIN_EN
      chain_q <= chain_d;
`endif
    end
  end

  assign HOLD  = hold_q;
  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Bench for bus_hold_arbiter: vector table, directed corner sequences and a randomized
// phase checked against rule-level expectations of the HOLD/HLDA arbitration protocol.
module tb_bus_hold_arbiter;

  localparam int N   = 4;
  localparam int MAX = 16;

  logic       CLK;
  logic       RESET;
  logic [3:0] REQ;
  logic       HLDA;
  logic       HOLD;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUSY;

  int tests = 0;
  int fails = 0;

  bus_hold_arbiter #(.NUM_REQ(N), .MAX_BURST(MAX)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .HLDA(HLDA),
    .HOLD(HOLD), .GNT(GNT), .OWNER(OWNER), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req;
    logic       hlda;
    logic       hold;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tv[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requester at or after p, wrapping; -1 when nobody asks.
  function automatic int rr(input logic [3:0] r, input int p);
    logic [3:0] t;
    for (int k = 0; k < N; k++) begin
      t = r >> ((p + k) % N);
      if (t[0]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    logic [3:0] t;
    for (int k = 0; k < N; k++) begin
      t = g >> k;
      if (t[0]) return k;
    end
    return -1;
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    REQ   = 4'b1111;
    HLDA  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("rst_hold", HOLD, 0);
      chk("rst_gnt", GNT, 0);
      chk("rst_busy", BUSY, 0);
    end
    chk("rst_owner", OWNER, 0);
    RESET = 1'b0;
    REQ   = 4'b0000;
    HLDA  = 1'b0;
  endtask

  // Processor stand-in: acknowledges HOLD changes one cycle later.
  task automatic auto_step();
    HLDA = HOLD;
    @(negedge CLK);
  endtask

  task automatic wait_gnt(input string name);
    int n;
    n = 0;
    while (GNT == 4'b0000 && n < 60) begin
      auto_step();
      n++;
    end
    if (GNT == 4'b0000) chk({name, "_timeout"}, 0, 1);
  endtask

  // Randomized phase state
  logic [3:0] p_req, p_gnt;
  logic       p_hlda;
  int         burst, ptr_m, grants, lat_cnt, own, w;
  bit         drop_pend, cont;
  int         want[4];
  int         served[4];
  int         order_exp[4];
  int         len;
  logic [3:0] m;

  initial begin
    RESET = 1'b1;
    REQ   = 4'b0000;
    HLDA  = 1'b0;

    tv[0]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tv[1]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tv[2]  = '{4'b0100, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b1};
    tv[3]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
    tv[4]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
    tv[5]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
    tv[6]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
    tv[7]  = '{4'b0100, 1'b1, 1'b1, 4'b0100, 2'd2, 1'b1};
    tv[8]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b1};
    tv[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1};
    tv[10] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};
    tv[11] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};
    tv[12] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 2'd2, 1'b1};
    tv[13] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 2'd2, 1'b1};
    tv[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd2, 1'b1};
    tv[15] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0};

    do_reset();
    for (int i = 0; i < 16; i++) begin
      REQ  = tv[i].req;
      HLDA = tv[i].hlda;
      @(negedge CLK);
      chk($sformatf("vec%0d {hold,gnt,owner,busy}", i), {HOLD, GNT, OWNER, BUSY},
          {tv[i].hold, tv[i].gnt, tv[i].owner, tv[i].busy});
    end

    // Single requester held forever: burst capped at MAX, then re-acquired.
    do_reset();
    REQ = 4'b0001;
    wait_gnt("t3_first");
    chk("t3_first_gnt", GNT, 4'b0001);
    len = 0;
    while (GNT[0] && len < 40) begin
      len++;
      auto_step();
    end
    chk("t3_burst_len", len, MAX);
`ifndef HOLD_CHAIN_EN
    chk("t3_hold_dead_cycle", HOLD, 1);
    auto_step();
    chk("t3_hold_drop", HOLD, 0);
`endif
    wait_gnt("t3_regrant");
    chk("t3_regrant_gnt", GNT, 4'b0001);
    // Asynchronous reset mid-burst, away from any clock edge.
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_gnt", GNT, 0);
    chk("async_rst_hold", HOLD, 0);
    chk("async_rst_busy", BUSY, 0);

    // Round-robin order across successive bursts.
    do_reset();
    REQ = 4'b1011;
    order_exp = '{0, 1, 3, 0};
    for (int g = 0; g < 4; g++) begin
      wait_gnt($sformatf("t4_wait%0d", g));
      chk($sformatf("t4_owner%0d", g), OWNER, order_exp[g]);
      chk($sformatf("t4_gnt%0d", g), GNT, 4'(1) << order_exp[g]);
      len = 0;
      while (GNT != 4'b0000 && len < 40) begin
        len++;
        auto_step();
      end
      chk($sformatf("t4_len%0d", g), len, MAX);
    end

    // HLDA withdrawn during GRANT.
    do_reset();
    REQ = 4'b0010;
    wait_gnt("t5_wait");
    auto_step();
    auto_step();
    chk("t5_gnt_before", GNT, 4'b0010);
    HLDA = 1'b0;
    REQ  = 4'b0000;
    @(negedge CLK);
    chk("t5_gnt_cleared", GNT, 0);
    chk("t5_hold_low", HOLD, 0);
    chk("t5_busy_rels", BUSY, 1);
    @(negedge CLK);
    chk("t5_idle", BUSY, 0);

`ifdef HOLD_CHAIN_EN
    // Chained handover keeps HOLD up with one empty grant cycle.
    do_reset();
    REQ = 4'b0011;
    wait_gnt("t6_wait");
    chk("t6_first", GNT, 4'b0001);
    auto_step();
    auto_step();
    REQ = 4'b0010;
    auto_step();
    chk("t6_dead_gnt", GNT, 0);
    chk("t6_dead_hold", HOLD, 1);
    auto_step();
    chk("t6_second", GNT, 4'b0010);
    chk("t6_second_hold", HOLD, 1);
`endif

    // Randomized traffic against protocol rules.
    do_reset();
    @(negedge CLK);
    p_req = REQ; p_hlda = HLDA; p_gnt = GNT;
    ptr_m = 0; burst = 0; grants = 0; lat_cnt = 0; drop_pend = 0;
    for (int i = 0; i < N; i++) begin
      want[i] = 1; served[i] = 0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge CLK);
      chk("r_onehot", ($countones(GNT) <= 1), 1);
      if (GNT != 4'b0000) chk("r_hold_with_gnt", HOLD, 1);
      if (HOLD) chk("r_busy_with_hold", BUSY, 1);
`ifndef HOLD_CHAIN_EN
      if (drop_pend) chk("r_release_after_drop", HOLD, 0);
`endif
      drop_pend = 0;
      if (p_gnt == 4'b0000 && GNT != 4'b0000) begin
        w = rr(p_req, ptr_m);
        chk("r_winner", GNT, 4'(1) << w);
        chk("r_owner", OWNER, w);
        chk("r_hlda_before_grant", p_hlda, 1);
        burst = 1;
        grants++;
      end else if (p_gnt != 4'b0000) begin
        own  = idx_of(p_gnt);
        m    = p_req >> own;
        cont = m[0] && p_hlda && (burst < MAX);
        chk("r_gnt_next", GNT, cont ? p_gnt : 4'b0000);
        if (cont) begin
          burst++;
        end else begin
          ptr_m = (own + 1) % N;
          chk("r_hold_after_gnt", HOLD, p_hlda);
          drop_pend = p_hlda;
        end
      end
      for (int i = 0; i < N; i++) begin
        m = 4'(1) << i;
        if ((REQ & m) != 0) begin
          if ((GNT & m) != 0) served[i]++;
          if (served[i] >= want[i]) begin
            REQ = REQ & ~m;
            served[i] = 0;
          end
        end else if ($urandom_range(0, 7) == 0) begin
          REQ = REQ | m;
          want[i] = $urandom_range(1, 20);
        end
      end
      if (HLDA != HOLD) begin
        if (lat_cnt == 0) lat_cnt = $urandom_range(1, 3);
        lat_cnt--;
        if (lat_cnt == 0) HLDA = HOLD;
      end else begin
        lat_cnt = 0;
      end
      p_req  = REQ;
      p_hlda = HLDA;
      p_gnt  = GNT;
    end
    chk("r_progress", (grants > 30), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
